// File: rtl/huge_page_tx_wr.sv
// Drains BRAM frames into host huge pages as MWr64 TLPs on the TRN TX interface.
// Optional idle-timeout early page close is enabled by defining HUGE_PAGE_TIMEOUT_EN.
module huge_page_tx_wr #(
  parameter int  HP_BYTES       = 2097152,
  parameter int  SLOT_BYTES     = 128,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int MAX_QW         = SLOT_BYTES / 8,
  localparam int OFF_W          = $clog2(HP_BYTES) + 1,
  localparam int LEN_W          = $clog2(MAX_QW + 1)
) (
  input  logic             trn_clk,
  input  logic             reset_n,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  output logic             trn_tsrc_dsc_n,
  input  logic             trn_tdst_rdy_n,
  input  logic [3:0]       trn_tbuf_av,
  input  logic [15:0]      cfg_completer_id,
  input  logic [63:0]      huge_page_addr_1,
  input  logic [63:0]      huge_page_addr_2,
  input  logic             huge_page_to_hw_1,
  input  logic             huge_page_to_hw_2,
  output logic             huge_page_to_host_1,
  output logic             huge_page_to_host_2,
  input  logic             frame_rdy,
  input  logic [4:0]       frame_len_qw,
  output logic             frame_done,
  output logic [8:0]       rd_addr,
  input  logic [63:0]      rd_data,
  output logic [OFF_W-1:0] page_fill_bytes
);

  typedef enum logic [2:0] {IDLE, WAIT_PAGE, HDR0, HDR1, DATA, ADV, CLOSE} state_t;

  state_t           state_q, state_d;
  logic             page_q, page_d;
  logic [OFF_W-1:0] offset_q, offset_d, fill_q, fill_d;
  logic [8:0]       base_q, base_d, idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d, len_eff;
  logic             done_q, done_d, host1_q, host1_d, host2_q, host2_d;
  logic             page_owned, out_vld, accept, last_beat;
  logic [63:0]      host_addr;
  logic [9:0]       len_dw;
  logic [4:0]       unused_bits;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign page_owned  = page_q ? huge_page_to_hw_2 : huge_page_to_hw_1;
  assign host_addr   = (page_q ? huge_page_addr_2 : huge_page_addr_1) + 64'(offset_q);
  assign out_vld     = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
  assign accept      = out_vld && !trn_tdst_rdy_n;
  assign last_beat   = (beat_q == len_q - LEN_W'(1));
  assign len_dw      = 10'({len_q, 1'b0});
  assign len_eff     = (frame_len_qw == 5'd0 || 32'(frame_len_qw) > MAX_QW) ?
                       LEN_W'(MAX_QW) : LEN_W'(frame_len_qw);
  assign unused_bits = {trn_tbuf_av[3:2], trn_tbuf_av[0], host_addr[1:0]};

  assign trn_trem_n          = 8'h00;
  assign trn_tsrc_dsc_n      = 1'b1;
  assign trn_tsrc_rdy_n      = !out_vld;
  assign frame_done          = done_q;
  assign huge_page_to_host_1 = host1_q;
  assign huge_page_to_host_2 = host2_q;
  assign page_fill_bytes     = fill_q;
  // rd_addr presents the next index, so rd_data always holds the word at idx_q
  // and a stalled beat simply keeps re-reading the same address.
  assign rd_addr             = idx_d;

`ifdef HUGE_PAGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    trn_td     = '0;
    trn_tsof_n = 1'b1;
    trn_teof_n = 1'b1;
    case (state_q)
      HDR0: begin
        trn_tsof_n = 1'b0;
        trn_td     = {1'b0, 2'b11, 5'b00000, 8'h00, 6'h00, len_dw,
                      cfg_completer_id, 8'h00, 4'hF, 4'hF};
      end
      HDR1: trn_td = {host_addr[63:32], host_addr[31:2], 2'b00};
      DATA: begin
        trn_td     = {bswap32(rd_data[31:0]), bswap32(rd_data[63:32])};
        trn_teof_n = !last_beat;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    offset_d = offset_q;
    fill_d   = fill_q;
    base_d   = base_q;
    idx_d    = base_q;
    len_d    = len_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    host1_d  = 1'b0;
    host2_d  = 1'b0;
`ifdef HUGE_PAGE_TIMEOUT_EN
    idle_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (frame_rdy) state_d = WAIT_PAGE;
`ifdef HUGE_PAGE_TIMEOUT_EN
        else if (offset_q != '0) begin
          if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = CLOSE;
          else idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
`endif
      end
      WAIT_PAGE: begin
        if (page_owned && trn_tbuf_av[1]) begin
          len_d   = len_eff;
          state_d = HDR0;
        end
      end
      HDR0: if (accept) state_d = HDR1;
      HDR1: begin
        if (accept) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        idx_d = idx_q;
        if (accept) begin
          idx_d  = idx_q + 9'd1;
          beat_d = beat_q + LEN_W'(1);
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = ADV;
          end
        end
      end
      ADV: begin
        offset_d = offset_q + OFF_W'(SLOT_BYTES);
        base_d   = base_q + 9'(len_q);
        idx_d    = base_d;
        state_d  = (offset_d == OFF_W'(HP_BYTES)) ? CLOSE : IDLE;
      end
      CLOSE: begin
        fill_d   = offset_q;
        host1_d  = !page_q;
        host2_d  = page_q;
        offset_d = '0;
        page_d   = !page_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      page_q   <= 1'b0;
      offset_q <= '0;
      fill_q   <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      host1_q  <= 1'b0;
      host2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      offset_q <= offset_d;
      fill_q   <= fill_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      host1_q  <= host1_d;
      host2_q  <= host2_d;
    end
  end

`ifdef HUGE_PAGE_TIMEOUT_EN
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) idle_cnt_q <= '0;
    else          idle_cnt_q <= idle_cnt_d;
  end
`endif

endmodule
